adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_pkg.sv | 22 ++
 rtl/Adder.sv | 21 ++
 rtl/adder_seq_ctrl.sv | 115 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial wide adder sequencer.
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_seq_state_t;

    // Width of the byte index; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/Adder.sv
// Existing 8-bit ripple-carry adder reused by the wide-add sequencer.
module Adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       carry_in,
    output logic [7:0] Y,
    output logic       carry_out
);

    logic [8:0] w_c;

    assign w_c[0] = carry_in;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign Y[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign carry_out = w_c[8];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder that time-multiplexes one 8-bit Adder, LSB byte first.
// Optional subtract support is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [BYTE_W*NBYTES-1:0] req_a,
    input  logic [BYTE_W*NBYTES-1:0] req_b,
    input  logic                     req_cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                     req_sub,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [BYTE_W*NBYTES-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic                     busy
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    adder_seq_state_t  r_state, w_next;
    logic [W-1:0]      r_a, r_b, r_sum;
    logic              r_carry, r_cout, r_ovf;
    logic [IDX_W-1:0]  r_idx;
    logic [BYTE_W-1:0] w_a_byte, w_b_byte, w_y;
    logic              w_co, w_accept, w_last, w_sub;

`ifdef ADDER_SEQ_SUB_EN
    assign w_sub = req_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W];
    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = req_valid && req_ready;

    Adder u_adder (
        .A         (w_a_byte),
        .B         (w_b_byte),
        .carry_in  (r_carry),
        .Y         (w_y),
        .carry_out (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too because they drive outputs that must read zero.
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= req_a;
            r_b     <= w_sub ? ~req_b : req_b;
            r_carry <= w_sub ? 1'b1 : req_cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*BYTE_W +: BYTE_W] <= w_y;
            r_carry <= w_co;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                // Signed overflow: like-signed operands producing an opposite-signed result.
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_y[BYTE_W-1] != r_a[W-1]);
            end
        end
    end

    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;
    assign rsp_ovf  = r_ovf;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (NBYTES=4) against an arithmetic reference model.
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
    logic         req_sub = 1'b0;
`endif
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    adder_seq_ctrl #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_SEQ_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide arithmetic; overflow when the wrapped signed result differs from the true one.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                  input logic sub, output logic [W-1:0] s, output logic c,
                                  output logic o);
        longint sd;
        longint unsigned u;
        if (sub) begin
            s  = a - b;
            c  = (a >= b);
            sd = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u  = longint'(a) + longint'(b) + longint'(cin);
            s  = u[W-1:0];
            c  = u[W];
            sd = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        o = (sd != longint'($signed(s)));
    endfunction

    // Issue one request, wait for its response, capture it and complete the handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] s, output logic c,
                         output logic o, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
        req_sub = sub;
`endif
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 50);
        if (!rsp_valid) ok = 1'b0;
        s = rsp_sum; c = rsp_cout; o = rsp_ovf;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({req_ready, rsp_valid, busy, rsp_cout, rsp_ovf, rsp_sum} !== {1'b1, 4'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, want rdy=1 others 0",
                     req_ready, rsp_valid, busy, rsp_cout, rsp_ovf, rsp_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] va[4] = '{32'h0000005E, 32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [W-1:0] vb[4] = '{32'h0000002C, 32'h00000001, 32'h00000000, 32'h00000001};
        logic         vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] es[4] = '{32'h0000008A, 32'h00000100, 32'h00000000, 32'h80000000};
        logic         eco[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic         eov[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] s;
        logic c, o;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, s, c, o, lat, ok);
            checks++;
            if ({ok, s, c, o} !== {1'b1, es[i], eco[i], eov[i]}) begin
                errors++;
                $display("FAIL directed_%0d: got ok=%b sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, ok, s, c, o, es[i], eco[i], eov[i]);
            end
            checks++;
            if (lat !== N) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles, want %0d", i, lat, N);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, s, es;
        logic cin, c, o, ec, eo;
        int lat;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom);
            if (i % 4 == 1) b = ~a;
            if (i % 4 == 2) begin a[W-1] = 1'b0; b[W-1] = 1'b0; end
            model(a, b, cin, 1'b0, es, ec, eo);
            do_op(a, b, cin, 1'b0, s, c, o, lat, ok);
            checks++;
            if ({ok, s, c, o} !== {1'b1, es, ec, eo}) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b got ok=%b sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, a, b, cin, ok, s, c, o, es, ec, eo);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] s0, es;
        logic c0, o0, ec, eo;
        int n;
        @(negedge clk);
        req_a = 32'h12345678; req_b = 32'h9ABCDEF0; req_cin = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_a = 32'h00FF00FF; req_b = 32'h00010001; req_cin = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        model(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, es, ec, eo);
        checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, es, ec, eo}) begin
            errors++;
            $display("FAIL bp_first: got vld=%b sum=%h cout=%b ovf=%b, want vld=1 sum=%h cout=%b ovf=%b",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf, es, ec, eo);
        end
        s0 = rsp_sum; c0 = rsp_cout; o0 = rsp_ovf;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, req_ready, busy, rsp_sum, rsp_cout, rsp_ovf} !== {3'b100, s0, c0, o0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b busy=%b sum=%h, want vld=1 rdy=0 busy=0 sum=%h",
                         k, rsp_valid, req_ready, busy, rsp_sum, s0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_idle_gap: got vld=%b rdy=%b busy=%b, want vld=0 rdy=1 busy=0",
                     rsp_valid, req_ready, busy);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if ({req_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL bp_second_accept: got rdy=%b busy=%b, want rdy=0 busy=1", req_ready, busy);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if ({rsp_valid, rsp_sum} !== {1'b1, 32'h01000100}) begin
            errors++;
            $display("FAIL bp_second: got vld=%b sum=%h, want vld=1 sum=01000100", rsp_valid, rsp_sum);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a[4], b[4], es;
        logic cin[4], ec, eo;
        int acc[3];
        int n;
        for (int k = 0; k < 4; k++) begin a[k] = $urandom; b[k] = $urandom; cin[k] = 1'($urandom); end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a = a[0]; req_b = b[0]; req_cin = cin[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!req_ready && n < 50) begin @(negedge clk); n++; end
            @(posedge clk);
            #1;
            acc[k] = cyc;
            req_a = a[k+1]; req_b = b[k+1]; req_cin = cin[k+1];
            if (k == 2) req_valid = 1'b0;
            model(a[k], b[k], cin[k], 1'b0, es, ec, eo);
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 50);
            checks++;
            if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, es, ec, eo}) begin
                errors++;
                $display("FAIL b2b_result_%0d: got vld=%b sum=%h cout=%b ovf=%b, want vld=1 sum=%h cout=%b ovf=%b",
                         k, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, es, ec, eo);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (acc[k] - acc[k-1] !== N + 2) begin
                errors++;
                $display("FAIL b2b_interval_%0d: got %0d cycles, want %0d", k, acc[k] - acc[k-1], N + 2);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] s;
        logic c, o;
        int lat;
        bit ok;
        bit seen;
        @(negedge clk);
        req_a = 32'hFFFFFFFF; req_b = 32'h80000001; req_cin = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_busy: got busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, rsp_cout, rsp_ovf, rsp_sum} !== {1'b1, 4'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_run_reset: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, want rdy=1 others 0",
                     req_ready, rsp_valid, busy, rsp_cout, rsp_ovf, rsp_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_no_response: got activity=%b after abort, want 0", seen);
        end
        do_op(32'h01010101, 32'h01010101, 1'b0, 1'b0, s, c, o, lat, ok);
        checks++;
        if ({ok, s, c, o} !== {1'b1, 32'h02020202, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_op: got ok=%b sum=%h cout=%b ovf=%b, want sum=02020202 cout=0 ovf=0",
                     ok, s, c, o);
        end
    endtask

`ifdef ADDER_SEQ_SUB_EN
    task automatic test_sub;
        logic [W-1:0] a, b, s, es;
        logic cin, c, o, ec, eo;
        int lat;
        bit ok;
        do_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, s, c, o, lat, ok);
        checks++;
        if ({ok, s, c, o} !== {1'b1, 32'hFFFFFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got ok=%b sum=%h cout=%b ovf=%b, want FFFFFFFE cout=0 ovf=0", ok, s, c, o);
        end
        do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, s, c, o, lat, ok);
        checks++;
        if ({ok, s, c, o} !== {1'b1, 32'h7FFFFFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf: got ok=%b sum=%h cout=%b ovf=%b, want 7FFFFFFF cout=1 ovf=1", ok, s, c, o);
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom);
            if (i % 3 == 0) b = a;
            model(a, b, cin, 1'b1, es, ec, eo);
            do_op(a, b, cin, 1'b1, s, c, o, lat, ok);
            checks++;
            if ({ok, s, c, o} !== {1'b1, es, ec, eo}) begin
                errors++;
                $display("FAIL sub_random_%0d: a=%h b=%h got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, a, b, s, c, o, es, ec, eo);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ADDER_SEQ_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
